mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipelined CPU memory-access stage, between the EX/MEM register and the MEM/WB register. It runs loads and stores against data memory over a req/ack handshake that tolerates wait states. It formats load data and generates store byte enables. It stalls the front of the pipeline while an access is outstanding, and hands the MEM/WB register one retired instruction (or a bubble) per cycle.

## Interface
- MAX_WAIT, 15: wait cycles allowed after the first request cycle before an access is aborted as a bus timeout (1..255).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid_i / ex_pc_i  in  1/32  instruction present and its PC, from EX/MEM.
- ex_rf_we_i / ex_wR_i / ex_wd_i  in  1/5/32  writeback enable, destination, non-load writeback data.
- ex_mem_rd_i / ex_mem_wr_i  in  1/1  load / store (never both).
- ex_funct3_i  in  3  access size/sign (RV32I encoding).
- ex_addr_i / ex_sdata_i  in  32/32  effective address, store data.
- dm_req_o / dm_we_o  out  1/1  bus request, write.
- dm_addr_o  out  32  word address, {ex_addr_i[31:2],2'b00}.
- dm_be_o / dm_wdata_o  out  4/32  byte enables, lane-aligned write data.
- dm_ack_i / dm_rdata_i  in  1/32  access complete, read word (valid with ack).
- stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle.
- err_o  out  1  one-cycle access fault (timeout or misalign).
- have_inst_o / pc_o / rf_we_o / wR_o / wD_o  out  1/32/1/5/32  to MEM/WB inputs.

## Operation
- States IDLE, WAIT. Registers: state, wait counter (8 bit), run_q.
- run_q resets to 0 and sets on the first clk edge after reset release. While run_q=0, every output is 0.
- Non-memory instruction in IDLE: combinational pass-through in the same cycle. have_inst_o=ex_valid_i, rf_we_o=ex_rf_we_i&ex_valid_i, wD_o=ex_wd_i, stall_o=0.
- Memory instruction in IDLE: dm_req_o=1.
  - If dm_ack_i=1 in the same cycle, the access retires with zero wait.
  - Otherwise stall_o=1, outputs are a bubble (have_inst_o=0, rf_we_o=0), and the next state is WAIT with counter=0.
- WAIT: dm_req_o is held with the same fields; upstream is frozen, so EX/MEM inputs stay stable. Each cycle without ack increments the counter.
  - Ack: the access retires this cycle, stall_o=0, next state IDLE.
  - Counter==MAX_WAIT with no ack: dm_req_o drops, err_o=1, have_inst_o=1, rf_we_o=0, stall_o=0, next state IDLE.
- Load result, byte lane = addr[1:0]:
  - LB/LBU select byte, sign/zero-extend.
  - LH/LHU select halfword addr[1], sign/zero-extend.
  - LW selects the full word.
  - funct3 011/110/111 yields 0.
- Store:
  - SB: be=4'b0001<<addr[1:0], wdata={4{sdata[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{sdata[15:0]}}.
  - SW: be=4'b1111.
  - Any other funct3: be=0, still handshaken.
- Retire: have_inst_o=1, pc_o=ex_pc_i, wR_o=ex_wR_i, rf_we_o=ex_rf_we_i. wD_o = formatted load data for loads, ex_wd_i for stores.
- An ack arriving while dm_req_o=0 is ignored.

## Timing
- Zero-wait access: retires in the request cycle, no stall.
- N-wait access: N stall cycles, then retires in the ack cycle.
- Timeout: faults in cycle MAX_WAIT+1 after the first request cycle.
- Reset asserted mid-WAIT: dm_req_o, stall_o and all outputs go 0 immediately (asynchronously). state=IDLE, counter=0, run_q=0.
- Back-to-back memory instructions: the next request is issued in the cycle after retirement, with no idle gap.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Faulting accesses: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Behaviour: no request is issued. In the same cycle err_o=1, have_inst_o=1, rf_we_o=0, no stall.
- Undefined:
  - No misalign check; low address bits beyond lane selection are ignored.
  - err_o is asserted only on timeout.

## Test plan
- Reset release: first cycle with run_q=0 shows all outputs 0 despite ex_valid_i=1. On the next cycle an ALU op (wR=5, wd=0x1234) passes: rf_we_o=1, wD_o=0x1234.
- LB addr=0x103, rdata=0x80FF_FF7F, zero-wait ack -> wD_o=0xFFFF_FF80, stall_o=0. Same access as LBU -> 0x0000_0080.
- SH addr=0x202, sdata=0xABCD_1234, ack after 3 wait cycles:
  - During the wait: stall_o=1 for 3 cycles, have_inst_o=0, dm_be_o=4'b1100, dm_wdata_o=0x1234_1234, dm_addr_o=0x200.
  - Retire cycle: stall_o=0, have_inst_o=1, rf_we_o=ex_rf_we_i (0).
- LW, never acked, MAX_WAIT=15 -> dm_req_o high 16 cycles, err_o=1 for one cycle, rf_we_o=0, state back to IDLE.
- rst_n low in the second WAIT cycle -> dm_req_o=0 and stall_o=0 immediately. After release, a fresh LW acked with rdata=0xDEADBEEF retires wD_o=0xDEADBEEF.
- With MEM_ALIGN_CHECK_EN, LW addr=0x102 -> no dm_req_o, err_o=1, have_inst_o=1, rf_we_o=0. Without the macro, the same access reads word 0x100.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack bus between the memory-access stage and data memory.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipelined load/store stage with wait-state handshake, timeout and stall generation.
// Optional misalign fault on halfword/word accesses when MEM_ALIGN_CHECK_EN is defined.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid_i,
  input  logic [31:0]             ex_pc_i,
  input  logic                    ex_rf_we_i,
  input  logic [4:0]              ex_wR_i,
  input  logic [31:0]             ex_wd_i,
  input  logic                    ex_mem_rd_i,
  input  logic                    ex_mem_wr_i,
  input  logic [2:0]              ex_funct3_i,
  input  logic [31:0]             ex_addr_i,
  input  logic [31:0]             ex_sdata_i,
  mem_access_stage_if.master      dm,
  output logic                    stall_o,
  output logic                    err_o,
  output logic                    have_inst_o,
  output logic [31:0]             pc_o,
  output logic                    rf_we_o,
  output logic [4:0]              wR_o,
  output logic [31:0]             wD_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        run_q;
  logic        mem, half, word, mis, waiting, tmo, req, ack, fault, pass, st;
  logic [31:0] shifted, ld, wd;
  logic [15:0] h;
  logic [7:0]  b;
  logic [3:0]  be;
  always_comb begin
    mem     = ex_valid_i & (ex_mem_rd_i | ex_mem_wr_i);
    half    = (ex_funct3_i == 3'b001) | (ex_mem_rd_i & ex_funct3_i == 3'b101);
    word    = ex_funct3_i == 3'b010;
`ifdef MEM_ALIGN_CHECK_EN
    mis     = mem & ((half & ex_addr_i[0]) | (word & |ex_addr_i[1:0]));
`else
    mis     = 1'b0 & half & word;
`endif
    waiting = state_q == WAIT;
    // WAIT does not re-check ex_valid_i: upstream is frozen while we stall
    tmo     = run_q & waiting & (cnt_q == 8'(MAX_WAIT)) & ~dm.ack;
    req     = run_q & (waiting ? ~tmo : mem & ~mis);
    ack     = req & dm.ack;
    fault   = tmo | (run_q & ~waiting & mis);
    pass    = run_q & ~waiting & ~mem & ex_valid_i;
    st      = req & ex_mem_wr_i;
    shifted = dm.rdata >> {ex_addr_i[1:0], 3'b000};
    b       = shifted[7:0];
    h       = ex_addr_i[1] ? dm.rdata[31:16] : dm.rdata[15:0];
    ld      = ex_funct3_i == 3'b000 ? {{24{b[7]}}, b} :
              ex_funct3_i == 3'b100 ? {24'b0, b} :
              ex_funct3_i == 3'b001 ? {{16{h[15]}}, h} :
              ex_funct3_i == 3'b101 ? {16'b0, h} :
              ex_funct3_i == 3'b010 ? dm.rdata : 32'b0;
    be      = ex_funct3_i == 3'b000 ? 4'b0001 << ex_addr_i[1:0] :
              ex_funct3_i == 3'b001 ? (ex_addr_i[1] ? 4'b1100 : 4'b0011) :
              ex_funct3_i == 3'b010 ? 4'b1111 : 4'b0000;
    wd      = ex_funct3_i == 3'b000 ? {4{ex_sdata_i[7:0]}} :
              ex_funct3_i == 3'b001 ? {2{ex_sdata_i[15:0]}} : ex_sdata_i;
    dm.req      = req;
    dm.we       = st;
    dm.addr     = req ? {ex_addr_i[31:2], 2'b00} : 32'b0;
    dm.be       = st ? be : 4'b0;
    dm.wdata    = st ? wd : 32'b0;
    stall_o     = req & ~dm.ack;
    err_o       = fault;
    have_inst_o = pass | ack | fault;
    pc_o        = have_inst_o ? ex_pc_i : 32'b0;
    wR_o        = have_inst_o ? ex_wR_i : 5'b0;
    rf_we_o     = (pass | ack) & ex_rf_we_i;
    wD_o        = (pass | ack) ? (ex_mem_rd_i ? ld : ex_wd_i) : 32'b0;
    state_d     = stall_o ? WAIT : IDLE;
    cnt_d       = (waiting & stall_o) ? cnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed stimulus with a retirement scoreboard for mem_access_stage.
module tb_mem_access_stage;
  logic        clk, rst_n;
  logic        ex_valid, ex_rf_we, ex_rd, ex_wr;
  logic [31:0] ex_pc, ex_wd, ex_addr, ex_sdata;
  logic [4:0]  ex_wR;
  logic [2:0]  ex_f3;
  logic        stall_o, err_o, have_inst_o, rf_we_o;
  logic [31:0] pc_o, wD_o;
  logic [4:0]  wR_o;
  int          n_tests = 0;
  int          n_fail = 0;
  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  wR;
    logic [31:0] wD;
    logic        err;
  } exp_t;
  exp_t q[$];
  mem_access_stage_if bus();
  mem_access_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_rf_we_i(ex_rf_we), .ex_wR_i(ex_wR),
    .ex_wd_i(ex_wd), .ex_mem_rd_i(ex_rd), .ex_mem_wr_i(ex_wr), .ex_funct3_i(ex_f3),
    .ex_addr_i(ex_addr), .ex_sdata_i(ex_sdata), .dm(bus),
    .stall_o(stall_o), .err_o(err_o), .have_inst_o(have_inst_o), .pc_o(pc_o),
    .rf_we_o(rf_we_o), .wR_o(wR_o), .wD_o(wD_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] wr,
                    input logic [31:0] wd, input logic rd, input logic st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] sd);
    ex_valid = v; ex_pc = pc; ex_rf_we = we; ex_wR = wr; ex_wd = wd;
    ex_rd = rd; ex_wr = st; ex_f3 = f3; ex_addr = a; ex_sdata = sd;
  endtask
  task automatic mem(input logic a, input logic [31:0] d);
    bus.ack = a;
    bus.rdata = d;
  endtask
  task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic e);
    exp_t x;
    x.pc = pc; x.rf_we = we; x.wR = wr; x.wD = wd; x.err = e;
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    if (rst_n && have_inst_o) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_retire: got pc %h expected no retirement", pc_o);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("ret_pc", pc_o, x.pc);
        chk("ret_rf_we", {31'b0, rf_we_o}, {31'b0, x.rf_we});
        chk("ret_wR", {27'b0, wR_o}, {27'b0, x.wR});
        chk("ret_wD", wD_o, x.wD);
        chk("ret_err", {31'b0, err_o}, {31'b0, x.err});
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    mem(1'b0, 32'b0);
    ex(1, 32'h10, 1, 5, 32'h1234, 0, 0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_have", {31'b0, have_inst_o}, 0);
    chk("rst_rf_we", {31'b0, rf_we_o}, 0);
    chk("rst_wD", wD_o, 0);
    cyc();
    push(32'h10, 1, 5, 32'h1234, 0);
    @(negedge clk);
    chk("alu_stall", {31'b0, stall_o}, 0);
    cyc();
    ex(1, 32'h14, 1, 6, 32'h5555, 1, 0, 3'b000, 32'h103, 32'h0);
    mem(1'b1, 32'h80FF_FF7F);
    push(32'h14, 1, 6, 32'hFFFF_FF80, 0);
    @(negedge clk);
    chk("lb_req", {31'b0, bus.req}, 1);
    chk("lb_addr", bus.addr, 32'h100);
    chk("lb_stall", {31'b0, stall_o}, 0);
    cyc();
    ex(1, 32'h18, 1, 6, 32'h5555, 1, 0, 3'b100, 32'h103, 32'h0);
    push(32'h18, 1, 6, 32'h0000_0080, 0);
    @(negedge clk);
    cyc();
    ex(1, 32'h1C, 0, 0, 32'h77, 0, 1, 3'b001, 32'h202, 32'hABCD_1234);
    mem(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sh_wait_stall", {31'b0, stall_o}, 1);
      chk("sh_wait_have", {31'b0, have_inst_o}, 0);
      chk("sh_wait_be", {28'b0, bus.be}, 32'hC);
      chk("sh_wait_wdata", bus.wdata, 32'h1234_1234);
      chk("sh_wait_addr", bus.addr, 32'h200);
      cyc();
    end
    mem(1'b1, 32'h0);
    push(32'h1C, 0, 0, 32'h77, 0);
    @(negedge clk);
    chk("sh_ret_stall", {31'b0, stall_o}, 0);
    cyc();
    ex(1, 32'h20, 1, 8, 32'h0, 1, 0, 3'b001, 32'h102, 32'h0);
    mem(1'b0, 32'h8001_7FFF);
    @(negedge clk);
    chk("lh_wait_stall", {31'b0, stall_o}, 1);
    cyc();
    mem(1'b1, 32'h8001_7FFF);
    push(32'h20, 1, 8, 32'hFFFF_8001, 0);
    @(negedge clk);
    cyc();
    ex(1, 32'h24, 1, 9, 32'h0, 1, 0, 3'b101, 32'h100, 32'h0);
    push(32'h24, 1, 9, 32'h0000_7FFF, 0);
    @(negedge clk);
    chk("b2b_req", {31'b0, bus.req}, 1);
    cyc();
    ex(1, 32'h28, 1, 10, 32'h99, 1, 0, 3'b011, 32'h100, 32'h0);
    push(32'h28, 1, 10, 32'h0, 0);
    @(negedge clk);
    cyc();
    ex(1, 32'h2C, 0, 0, 32'h42, 0, 1, 3'b000, 32'h301, 32'h0000_00AB);
    push(32'h2C, 0, 0, 32'h42, 0);
    @(negedge clk);
    chk("sb_be", {28'b0, bus.be}, 32'h2);
    chk("sb_wdata", bus.wdata, 32'hABAB_ABAB);
    chk("sb_we", {31'b0, bus.we}, 1);
    cyc();
    ex(1, 32'h30, 0, 0, 32'h43, 0, 1, 3'b010, 32'h304, 32'h1122_3344);
    push(32'h30, 0, 0, 32'h43, 0);
    @(negedge clk);
    chk("sw_be", {28'b0, bus.be}, 32'hF);
    chk("sw_wdata", bus.wdata, 32'h1122_3344);
    cyc();
    ex(1, 32'h34, 1, 11, 32'hBEEF, 0, 0, 3'b000, 32'h0, 32'h0);
    push(32'h34, 1, 11, 32'hBEEF, 0);
    @(negedge clk);
    chk("ack_ignored_req", {31'b0, bus.req}, 0);
    cyc();
    ex(1, 32'h40, 1, 7, 32'h0, 1, 0, 3'b010, 32'h400, 32'h0);
    mem(1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_req", {31'b0, bus.req}, 1);
      chk("tmo_stall", {31'b0, stall_o}, 1);
      cyc();
    end
    push(32'h40, 0, 7, 32'h0, 1);
    @(negedge clk);
    chk("tmo_fault_req", {31'b0, bus.req}, 0);
    chk("tmo_fault_stall", {31'b0, stall_o}, 0);
    cyc();
    ex(0, 32'h0, 0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("tmo_err_once", {31'b0, err_o}, 0);
    cyc();
    ex(1, 32'h50, 1, 12, 32'h0, 1, 0, 3'b010, 32'h500, 32'h0);
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus.req}, 0);
    chk("arst_stall", {31'b0, stall_o}, 0);
    chk("arst_have", {31'b0, have_inst_o}, 0);
    mem(1'b1, 32'hDEAD_BEEF);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_run0_req", {31'b0, bus.req}, 0);
    cyc();
    push(32'h50, 1, 12, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("arst_fresh_req", {31'b0, bus.req}, 1);
    cyc();
    ex(1, 32'h60, 1, 13, 32'h0, 1, 0, 3'b010, 32'h102, 32'h0);
    mem(1'b1, 32'hCAFE_F00D);
`ifdef MEM_ALIGN_CHECK_EN
    push(32'h60, 0, 13, 32'h0, 1);
    @(negedge clk);
    chk("mis_req", {31'b0, bus.req}, 0);
    chk("mis_stall", {31'b0, stall_o}, 0);
`else
    push(32'h60, 1, 13, 32'hCAFE_F00D, 0);
    @(negedge clk);
    chk("mis_addr", bus.addr, 32'h100);
    chk("mis_err", {31'b0, err_o}, 0);
`endif
    cyc();
    ex(0, 32'h0, 0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
    mem(1'b0, 32'h0);
    cyc();
    @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
